// File: rtl/iob_eth_rx_deframer.sv
// MII receive deframer: finds preamble/SFD, packs nibbles into bytes, writes
// them to the RX buffer, checks CRC-32 and posts a held length/status descriptor.
module iob_eth_rx_deframer #(
  parameter int BUF_ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            rx_data,
  input  logic                  rx_dv,
  output logic                  buf_we,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [7:0]            buf_wdata,
  output logic                  frame_valid,
  output logic [BUF_ADDR_W:0]   frame_len,
  output logic                  crc_err,
  output logic                  align_err,
  output logic                  ovf_err,
  input  logic                  frame_ack,
  output logic [7:0]            drop_cnt
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [BUF_ADDR_W:0] CAP     = {1'b1, {BUF_ADDR_W{1'b0}}};
  localparam logic [BUF_ADDR_W:0] MIN_LEN = (BUF_ADDR_W+1)'(4);
  localparam logic [31:0]         RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0]         POLY    = 32'hEDB88320;

  // Reflected CRC-32 over one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [31:0]           crc_q, crc_d;
  logic [BUF_ADDR_W:0]   count_q, count_d;
  logic                  phase_q, phase_d;
  logic [3:0]            low_q, low_d;
  logic                  ovf_q, ovf_d;
  logic                  buf_we_q, buf_we_d;
  logic [BUF_ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]            buf_wdata_q, buf_wdata_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [BUF_ADDR_W:0]   frame_len_q, frame_len_d;
  logic                  crc_err_q, crc_err_d;
  logic                  align_err_q, align_err_d;
  logic                  ovf_err_q, ovf_err_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [7:0]            byte_w;

  assign byte_w = {rx_data, low_q};

  // Next-state, datapath and descriptor logic.
  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    count_d       = count_q;
    phase_d       = phase_q;
    low_d         = low_q;
    ovf_d         = ovf_q;
    buf_we_d      = 1'b0;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    crc_err_d     = crc_err_q;
    align_err_d   = align_err_q;
    ovf_err_d     = ovf_err_q;
    drop_cnt_d    = drop_cnt_q;

    // Acknowledge only retires a posted descriptor; fields are left as they were.
    if (frame_valid_q && frame_ack) begin
      frame_valid_d = 1'b0;
    end

    case (state_q)
      S_WAIT_IDLE: begin
        if (!rx_dv) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rx_dv) begin
          // Pre-edge frame_valid decides, so an ack on this same edge still drops.
          if (frame_valid_q) begin
            state_d = S_DROP;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          end else if (rx_data == 4'h5) begin
            state_d = S_PREAMBLE;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rx_data == 4'hD) begin
          state_d = S_DATA;
          count_d = '0;
          crc_d   = 32'hFFFFFFFF;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end else if (rx_data != 4'h5) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (rx_dv) begin
          if (!phase_q) begin
            low_d   = rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_byte(crc_q, byte_w);
            // Bytes past capacity still feed the CRC but are not stored.
            if (count_q < CAP) begin
              buf_we_d    = 1'b1;
              buf_addr_d  = count_q[BUF_ADDR_W-1:0];
              buf_wdata_d = byte_w;
              count_d     = count_q + (BUF_ADDR_W+1)'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          state_d       = S_IDLE;
          frame_valid_d = 1'b1;
          frame_len_d   = count_q;
          crc_err_d     = (crc_q != RESIDUE) || (count_q < MIN_LEN);
          align_err_d   = phase_q;
          ovf_err_d     = ovf_q;
        end
      end
      S_DROP: begin
        if (!rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_WAIT_IDLE;
      crc_q         <= 32'hFFFFFFFF;
      count_q       <= '0;
      phase_q       <= 1'b0;
      low_q         <= 4'd0;
      ovf_q         <= 1'b0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      crc_err_q     <= 1'b0;
      align_err_q   <= 1'b0;
      ovf_err_q     <= 1'b0;
      drop_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      count_q       <= count_d;
      phase_q       <= phase_d;
      low_q         <= low_d;
      ovf_q         <= ovf_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      crc_err_q     <= crc_err_d;
      align_err_q   <= align_err_d;
      ovf_err_q     <= ovf_err_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_wdata   = buf_wdata_q;
  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign crc_err     = crc_err_q;
  assign align_err   = align_err_q;
  assign ovf_err     = ovf_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_deframer.sv
// Bench for iob_eth_rx_deframer: two instances (2048-byte and 64-byte buffers)
// share one MII stimulus; a frame-level model predicts writes and descriptors.
module tb_iob_eth_rx_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rx_data = 4'd0;
  logic       rx_dv = 1'b0;
  logic       frame_ack = 1'b0;

  logic        we11, fv11, ce11, ae11, oe11;
  logic [10:0] addr11;
  logic [7:0]  wd11, drop11;
  logic [11:0] len11;
  logic        we6, fv6, ce6, ae6, oe6;
  logic [5:0]  addr6;
  logic [7:0]  wd6, drop6;
  logic [6:0]  len6;

  iob_eth_rx_deframer #(.BUF_ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv),
    .buf_we(we11), .buf_addr(addr11), .buf_wdata(wd11),
    .frame_valid(fv11), .frame_len(len11), .crc_err(ce11), .align_err(ae11),
    .ovf_err(oe11), .frame_ack(frame_ack), .drop_cnt(drop11));

  iob_eth_rx_deframer #(.BUF_ADDR_W(6)) dut6 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv),
    .buf_we(we6), .buf_addr(addr6), .buf_wdata(wd6),
    .frame_valid(fv6), .frame_len(len6), .crc_err(ce6), .align_err(ae6),
    .ovf_err(oe6), .frame_ack(frame_ack), .drop_cnt(drop6));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] frm[$];
  int q11[$];
  int q6[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard Ethernet FCS of the first n bytes of frm.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Payload of npay bytes starting at value off, followed by its FCS LSB first.
  task automatic build(input int npay, input int off);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < npay; i++) frm.push_back(8'(i + off));
    f = fcs_of(npay);
    for (int k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [3:0] d);
    rx_dv = dv;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  // Sends frm; rst_byte >= 0 pulses reset for two clocks at that byte.
  task automatic send_frame(input bit extra, input bit dropped, input int rst_byte);
    int len;
    len = frm.size();
    if (!dropped) begin
      for (int i = 0; i < len; i++) begin
        if (rst_byte < 0 || i < rst_byte) begin
          if (i < 2048) q11.push_back(i * 256 + int'(frm[i]));
          if (i < 64) q6.push_back(i * 256 + int'(frm[i]));
        end
      end
    end
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < len; i++) begin
      if (i == rst_byte) begin
        @(negedge clk);
        #1 reset = 1'b1;
      end
      drive(1'b1, frm[i][3:0]);
      drive(1'b1, frm[i][7:4]);
      if (i == rst_byte) reset = 1'b0;
    end
    if (extra) drive(1'b1, 4'hA);
    drive(1'b0, 4'h0);
  endtask

  // Descriptor both instances must show for the frame just sent.
  task automatic check_desc(input string t, input bit align);
    int len;
    bit ce;
    len = frm.size();
    ce = (len < 4);
    if (len >= 4) ce = (fcs_of(len - 4) != {frm[len-1], frm[len-2], frm[len-3], frm[len-4]});
    check({t, "_fv11"}, 32'(fv11), 32'd1);
    check({t, "_len11"}, 32'(len11), 32'(len < 2048 ? len : 2048));
    check({t, "_crc11"}, 32'(ce11), 32'(ce));
    check({t, "_align11"}, 32'(ae11), 32'(align));
    check({t, "_ovf11"}, 32'(oe11), 32'(len > 2048));
    check({t, "_fv6"}, 32'(fv6), 32'd1);
    check({t, "_len6"}, 32'(len6), 32'(len < 64 ? len : 64));
    check({t, "_crc6"}, 32'(ce6), 32'(ce));
    check({t, "_align6"}, 32'(ae6), 32'(align));
    check({t, "_ovf6"}, 32'(oe6), 32'(len > 64));
  endtask

  task automatic ack(input string t);
    logic [11:0] l11;
    l11 = len11;
    frame_ack = 1'b1;
    drive(1'b0, 4'h0);
    frame_ack = 1'b0;
    check({t, "_ack_fv11"}, 32'(fv11), 32'd0);
    check({t, "_ack_fv6"}, 32'(fv6), 32'd0);
    check({t, "_ack_len_hold"}, 32'(len11), 32'(l11));
    drive(1'b0, 4'h0);
  endtask

  // Every write strobe must match the next predicted (address, byte).
  always @(negedge clk) begin
    if (!reset) begin
      if (we11) begin
        if (q11.size() == 0) check("wr11_unexpected", {21'd0, addr11}, 32'hFFFFFFFF);
        else check("wr11", 32'({addr11, wd11}), 32'(q11.pop_front()));
      end
      if (we6) begin
        if (q6.size() == 0) check("wr6_unexpected", {26'd0, addr6}, 32'hFFFFFFFF);
        else check("wr6", 32'({addr6, wd6}), 32'(q6.pop_front()));
      end
    end
  end

  initial begin
    // Pin the model's FCS against the well-known check value.
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    check("model_fcs_123456789", fcs_of(9), 32'hCBF43926);

    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(we11), 32'd0);
    check("rst_fv", 32'(fv11), 32'd0);
    check("rst_len", 32'(len11), 32'd0);
    check("rst_errs", 32'({ce11, ae11, oe11}), 32'd0);
    check("rst_drop", 32'(drop11), 32'd0);
    check("rst_addr_data", 32'({addr11, wd11}), 32'd0);
    reset = 1'b0;
    repeat (3) drive(1'b0, 4'h0);

    // Good 64-byte frame.
    build(60, 0);
    send_frame(1'b0, 1'b0, -1);
    check_desc("good", 1'b0);
    check("good_len_lit", 32'(len11), 32'd64);
    check("good_crc_lit", 32'(ce11), 32'd0);
    ack("good");

    // Corrupted payload bit.
    build(60, 0);
    frm[10] = frm[10] ^ 8'h01;
    send_frame(1'b0, 1'b0, -1);
    check_desc("bad", 1'b0);
    check("bad_crc_lit", 32'(ce11), 32'd1);
    ack("bad");

    // Trailing odd nibble.
    build(60, 0);
    send_frame(1'b1, 1'b0, -1);
    check_desc("odd", 1'b1);
    check("odd_align_lit", 32'(ae11), 32'd1);
    ack("odd");

    // 100-byte frame overflows the 64-byte instance only.
    build(96, 7);
    send_frame(1'b0, 1'b0, -1);
    check_desc("big", 1'b0);
    check("big_len6_lit", 32'(len6), 32'd64);
    check("big_ovf6_lit", 32'(oe6), 32'd1);
    check("big_crc6_lit", 32'(ce6), 32'd0);
    ack("big");

    // Runt frame without FCS.
    frm.delete();
    frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
    send_frame(1'b0, 1'b0, -1);
    check_desc("runt", 1'b0);
    check("runt_crc_lit", 32'(ce11), 32'd1);
    ack("runt");

    // Descriptor busy: A posted, B dropped, then C after ack.
    build(20, 50);
    send_frame(1'b0, 1'b0, -1);
    check_desc("a", 1'b0);
    build(30, 100);
    send_frame(1'b0, 1'b1, -1);
    repeat (2) drive(1'b0, 4'h0);
    check("b_drop11", 32'(drop11), 32'd1);
    check("b_drop6", 32'(drop6), 32'd1);
    check("b_fv_still_a", 32'(fv11), 32'd1);
    check("b_len_still_a", 32'(len11), 32'd24);
    check("b_crc_still_a", 32'(ce11), 32'd0);
    ack("a");
    build(22, 200);
    send_frame(1'b0, 1'b0, -1);
    check_desc("c", 1'b0);
    check("c_drop_hold", 32'(drop11), 32'd1);
    ack("c");

    // Reset at byte 20 with a 0x5/0xD nibble pair later in the payload.
    build(60, 0);
    frm[30] = 8'h55;
    frm[31] = 8'hD5;
    send_frame(1'b0, 1'b0, 20);
    check("rst_mid_fv", 32'(fv11), 32'd0);
    check("rst_mid_fv6", 32'(fv6), 32'd0);
    check("rst_mid_drop", 32'(drop11), 32'd0);
    repeat (3) drive(1'b0, 4'h0);
    check("rst_mid_fv_late", 32'(fv11), 32'd0);
    build(60, 3);
    send_frame(1'b0, 1'b0, -1);
    check_desc("after_rst", 1'b0);
    ack("after_rst");

    repeat (3) drive(1'b0, 4'h0);
    check("pending_wr11", 32'(q11.size()), 32'd0);
    check("pending_wr6", 32'(q6.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
